// File: rtl/hamming_pkg.sv
// Shared helpers for the extended-Hamming SECDED decoder: parity-width
// calculation and codeword position mapping for data bits.
package hamming_pkg;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Smallest p with 2^p >= data_w + p + 1; scanning downward leaves the minimum.
  function automatic int calc_p(input int data_w);
    int p;
    p = 0;
    for (int k = 30; k >= 1; k--) begin
      if ((longint'(1) << k) >= longint'(data_w + k + 1)) p = k;
    end
    return p;
  endfunction

  // Data bits fill the non-power-of-two positions of 1..CW-1 in ascending order.
  function automatic int data_pos(input int i);
    int cnt;
    int pos;
    cnt = -1;
    pos = 0;
    for (int q = 1; q <= i + 33; q++) begin
      if (!is_pow2(q)) begin
        cnt = cnt + 1;
        if (pos == 0 && cnt == i) pos = q;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for an extended
// Hamming codeword (bit 0 = overall parity, bits 1..CW-1 = Hamming positions).
module hamming_syndrome #(
  parameter int CW = 8,
  parameter int P  = 3
) (
  input  logic [CW-1:0] code,
  output logic [P-1:0]  syndrome,
  output logic          par
);

  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CW; i++) begin
      if (code[i]) syndrome = syndrome ^ P'(i);
    end
    par = ^code;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined extended-Hamming SECDED decoder with valid/ready flow
// control; saturating error counters exist only when HAMMING_ERR_CNT_EN is defined.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
  localparam int P  = calc_p(DATA_W),
  localparam int CW = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [P-1:0]      out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; a producer holding valid keeps its payload stable until that edge.
  // in_ready is combinational from out_ready (no skid buffer), so at most two
  // words (stage 1 + output register) are ever in flight.
  logic              s1_valid;
  logic [CW-1:0]     s1_code;
  logic              s1_en;
  logic [P-1:0]      s1_syn;
  logic              s1_par;
  logic              s1_adv;
  logic              s2_adv;

  logic [P-1:0]      in_syn;
  logic              in_par;
  logic [CW-1:0]     fix_mask;
  logic [CW-1:0]     s1_cor;
  logic [DATA_W-1:0] nxt_data;
  logic              nxt_sec;
  logic              nxt_ded;
  logic              unused_cor;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  hamming_syndrome #(.CW(CW), .P(P)) u_syn (
    .code     (in_code),
    .syndrome (in_syn),
    .par      (in_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_en    <= 1'b0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_en   <= en;
        s1_syn  <= in_syn;
        s1_par  <= in_par;
      end
    end
  end

  // A bit-0 error leaves the data untouched; an out-of-range syndrome with odd
  // parity cannot be a single error, so it is reported as uncorrectable.
  always_comb begin
    fix_mask = '0;
    nxt_sec  = 1'b0;
    nxt_ded  = 1'b0;
    if (s1_en) begin
      if (s1_par) begin
        if (s1_syn == '0) begin
          nxt_sec = 1'b1;
        end else if (int'(s1_syn) <= CW - 1) begin
          nxt_sec = 1'b1;
          for (int i = 1; i < CW; i++) begin
            if (int'(s1_syn) == i) fix_mask[i] = 1'b1;
          end
        end else begin
          nxt_ded = 1'b1;
        end
      end else if (s1_syn != '0) begin
        nxt_ded = 1'b1;
      end
    end
  end

  assign s1_cor     = s1_code ^ fix_mask;
  assign unused_cor = ^s1_cor;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
    localparam int POS = data_pos(gi);
    assign nxt_data[gi] = s1_cor[POS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sec      <= 1'b0;
      out_ded      <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= nxt_data;
        out_sec      <= nxt_sec;
        out_ded      <= nxt_ded;
        out_syndrome <= s1_syn;
      end
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] corr_q;
  logic [CNT_W-1:0] uncorr_q;

  // Clear takes priority over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (cnt_clr) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (out_valid && out_ready) begin
      if (out_sec && (corr_q != '1))   corr_q   <= corr_q + CNT_W'(1);
      if (out_ded && (uncorr_q != '1)) uncorr_q <= uncorr_q + CNT_W'(1);
    end
  end

  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder (DATA_W=4, CW=8, CNT_W=2); counter
// expectations follow whether HAMMING_ERR_CNT_EN is defined.
module tb_hamming_secded_decoder;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam int P      = 3;
  localparam int CW     = 8;
`ifdef HAMMING_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sec;
  logic              out_ded;
  logic [P-1:0]      out_syndrome;
  logic              cnt_clr;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  int checks = 0;
  int errors = 0;
  int exp_corr = 0;
  int exp_uncorr = 0;

  hamming_secded_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sec      (out_sec),
    .out_ded      (out_ded),
    .out_syndrome (out_syndrome),
    .cnt_clr      (cnt_clr),
    .corr_cnt     (corr_cnt),
    .uncorr_cnt   (uncorr_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat_inc(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
    return CNT_ON ? CNT_W'(v) : '0;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+#1 with an idle pipeline; returns edges from capture to out_valid.
  task automatic send_word(input logic [CW-1:0] code, input logic e, output int lat);
    in_code  = code;
    en       = e;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_word();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_sec, out_ded, out_syndrome} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {out_valid, out_data, out_sec, out_ded, out_syndrome});
    end
    checks++;
    if ({corr_cnt, uncorr_cnt} !== 4'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", corr_cnt, uncorr_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_clean();
    logic [CW-1:0]     codes [6] = '{8'hAA, 8'h0F, 8'h33, 8'h55, 8'h96, 8'h00};
    logic [DATA_W-1:0] datas [6] = '{4'hB, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      send_word(codes[i], 1'b1, lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL clean_latency code %h got %0d want 1", codes[i], lat);
      end
      checks++;
      if ({out_data, out_sec, out_ded, out_syndrome} !== {datas[i], 1'b0, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL clean_word code %h got d=%h s=%b d=%b syn=%0d want d=%h 0 0 0",
                 codes[i], out_data, out_sec, out_ded, out_syndrome, datas[i]);
      end
      take_word();
    end
  endtask

  task automatic test_single();
    logic [CW-1:0]     codes [3] = '{8'h8A, 8'hAB, 8'h07};
    logic [DATA_W-1:0] datas [3] = '{4'hB, 4'hB, 4'h1};
    logic [P-1:0]      syns  [3] = '{3'd5, 3'd0, 3'd3};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send_word(codes[i], 1'b1, lat);
      checks++;
      if ({out_valid, out_data, out_sec, out_ded, out_syndrome} !== {1'b1, datas[i], 1'b1, 1'b0, syns[i]}) begin
        errors++;
        $display("FAIL single_word code %h got v=%b d=%h s=%b d=%b syn=%0d want 1 %h 1 0 %0d",
                 codes[i], out_valid, out_data, out_sec, out_ded, out_syndrome, datas[i], syns[i]);
      end
      take_word();
      exp_corr = sat_inc(exp_corr);
      checks++;
      if (corr_cnt !== exp_cnt(exp_corr)) begin
        errors++;
        $display("FAIL single_corr_cnt got %0d want %0d", corr_cnt, exp_cnt(exp_corr));
      end
    end
  endtask

  task automatic test_double();
    logic [CW-1:0]     codes [2] = '{8'hCA, 8'h09};
    logic [DATA_W-1:0] datas [2] = '{4'hD, 4'h1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      send_word(codes[i], 1'b1, lat);
      checks++;
      if ({out_valid, out_data, out_sec, out_ded, out_syndrome} !== {1'b1, datas[i], 1'b0, 1'b1, 3'd3}) begin
        errors++;
        $display("FAIL double_word code %h got v=%b d=%h s=%b d=%b syn=%0d want 1 %h 0 1 3",
                 codes[i], out_valid, out_data, out_sec, out_ded, out_syndrome, datas[i]);
      end
      take_word();
      exp_uncorr = sat_inc(exp_uncorr);
      checks++;
      if ({corr_cnt, uncorr_cnt} !== {exp_cnt(exp_corr), exp_cnt(exp_uncorr)}) begin
        errors++;
        $display("FAIL double_counters got %0d/%0d want %0d/%0d",
                 corr_cnt, uncorr_cnt, exp_cnt(exp_corr), exp_cnt(exp_uncorr));
      end
    end
  endtask

  task automatic test_en_off();
    logic [CW-1:0]     codes [2] = '{8'hCA, 8'h8A};
    logic [DATA_W-1:0] datas [2] = '{4'hD, 4'h9};
    logic [P-1:0]      syns  [2] = '{3'd3, 3'd5};
    int lat;
    for (int i = 0; i < 2; i++) begin
      send_word(codes[i], 1'b0, lat);
      checks++;
      if ({out_valid, out_data, out_sec, out_ded, out_syndrome} !== {1'b1, datas[i], 1'b0, 1'b0, syns[i]}) begin
        errors++;
        $display("FAIL en_off_word code %h got v=%b d=%h s=%b d=%b syn=%0d want 1 %h 0 0 %0d",
                 codes[i], out_valid, out_data, out_sec, out_ded, out_syndrome, datas[i], syns[i]);
      end
      take_word();
    end
    checks++;
    if ({corr_cnt, uncorr_cnt} !== {exp_cnt(exp_corr), exp_cnt(exp_uncorr)}) begin
      errors++;
      $display("FAIL en_off_counters got %0d/%0d want %0d/%0d",
               corr_cnt, uncorr_cnt, exp_cnt(exp_corr), exp_cnt(exp_uncorr));
    end
    en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] codes [8] = '{8'h0F, 8'h33, 8'h8A, 8'h55, 8'h96, 8'hAA, 8'h00, 8'hCA};
    // {ded, sec, data}
    logic [5:0]    exps  [8] = '{6'h01, 6'h02, 6'h1B, 6'h04, 6'h08, 6'h0B, 6'h00, 6'h2D};
    logic [5:0]    exp_q [$];
    logic [5:0]    want;
    logic [8:0]    held;
    bit            held_v;
    int            idx;
    int            got;
    idx = 0; got = 0; held_v = 0; held = '0;
    en = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 3 && cyc < 6) ? 1'b0 : 1'b1;
      if (idx < 8) begin
        in_valid = 1'b1;
        in_code  = codes[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(exps[idx]);
        idx++;
      end
      if (cyc == 5) begin
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
          errors++;
          $display("FAIL b2b_stall_ready got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
        end
      end
      if (out_valid && !out_ready) begin
        if (held_v) begin
          checks++;
          if ({out_data, out_sec, out_ded, out_syndrome} !== held) begin
            errors++;
            $display("FAIL b2b_hold got %h want %h", {out_data, out_sec, out_ded, out_syndrome}, held);
          end
        end
        held   = {out_data, out_sec, out_ded, out_syndrome};
        held_v = 1;
      end else begin
        held_v = 0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got d=%h want none", out_data);
        end else begin
          want = exp_q.pop_front();
          if ({out_ded, out_sec, out_data} !== want) begin
            errors++;
            $display("FAIL b2b_word %0d got %h want %h", got, {out_ded, out_sec, out_data}, want);
          end
          if (want[4]) exp_corr = sat_inc(exp_corr);
          if (want[5]) exp_uncorr = sat_inc(exp_uncorr);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 8 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count got %0d words (%0d pending) want 8 (0)", got, exp_q.size());
    end
    @(posedge clk); #1;
    checks++;
    if ({corr_cnt, uncorr_cnt} !== {exp_cnt(exp_corr), exp_cnt(exp_uncorr)}) begin
      errors++;
      $display("FAIL b2b_counters got %0d/%0d want %0d/%0d",
               corr_cnt, uncorr_cnt, exp_cnt(exp_corr), exp_cnt(exp_uncorr));
    end
  endtask

  task automatic test_counters();
    int lat;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    checks++;
    if ({corr_cnt, uncorr_cnt} !== 4'd0) begin
      errors++;
      $display("FAIL cnt_clear got %0d/%0d want 0/0", corr_cnt, uncorr_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      send_word(8'h8A, 1'b1, lat);
      take_word();
      exp_corr = sat_inc(exp_corr);
      if (i == 1 || i == 4) begin
        checks++;
        if (corr_cnt !== exp_cnt(exp_corr)) begin
          errors++;
          $display("FAIL cnt_sat after %0d got %0d want %0d", i + 1, corr_cnt, exp_cnt(exp_corr));
        end
      end
    end
    send_word(8'hCA, 1'b1, lat);
    take_word();
    exp_uncorr = sat_inc(exp_uncorr);
    // Clear lands on the same edge as a corrected-word handshake.
    send_word(8'h8A, 1'b1, lat);
    cnt_clr = 1'b1;
    take_word();
    cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    checks++;
    if ({corr_cnt, uncorr_cnt} !== 4'd0) begin
      errors++;
      $display("FAIL cnt_clr_wins got %0d/%0d want 0/0", corr_cnt, uncorr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    send_word(8'h8A, 1'b1, lat);
    take_word();
    exp_corr = sat_inc(exp_corr);
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 8'h0F;
    @(posedge clk); #1;
    in_code = 8'h33;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, corr_cnt} !== {1'b0, 1'b1, exp_cnt(exp_corr)}) begin
      errors++;
      $display("FAIL mid_two_in_flight got in_ready=%b out_valid=%b corr=%0d want 0 1 %0d",
               in_ready, out_valid, corr_cnt, exp_cnt(exp_corr));
    end
    #2 rst_n = 1'b0;
    #1;
    exp_corr = 0; exp_uncorr = 0;
    checks++;
    if ({out_valid, corr_cnt, uncorr_cnt} !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset_async got v=%b %0d/%0d want 0 0/0", out_valid, corr_cnt, uncorr_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after_release got %0d outputs in_ready=%b want 0 1", seen, in_ready);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_en_off();
    test_back_to_back();
    test_counters();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
